// File: rtl/register_file_if.sv
// Register bank port bundle: write/clear controls driven by the master,
// read data and conversion window returned by the slave.
interface register_file_if #(
   parameter int DEPTH = 16,
   parameter int WIDTH = 8
);
   localparam int AW = $clog2(DEPTH);

   logic [AW-1:0]      sel_in_i;
   logic [AW-1:0]      sel_out_i;
   logic               load_i;
   logic               clear_i;
   logic [WIDTH-1:0]   in_i;
   logic [WIDTH-1:0]   out_o;
   logic [3*WIDTH-1:0] out_conversion_o;

   modport master (
      output sel_in_i,
      output sel_out_i,
      output load_i,
      output clear_i,
      output in_i,
      input  out_o,
      input  out_conversion_o
   );

   modport slave (
      input  sel_in_i,
      input  sel_out_i,
      input  load_i,
      input  clear_i,
      input  in_i,
      output out_o,
      output out_conversion_o
   );
endinterface

// File: rtl/register_file.sv
// DEPTH x WIDTH register bank: one write port, one combinational read port,
// synchronous clear and a fixed 3-register conversion-data window.
module register_file #(
   parameter int DEPTH     = 16,
   parameter int WIDTH     = 8,
   parameter int CONV_BASE = 0
) (
   input logic             clock_i,
   input logic             rst_ni,
   register_file_if.slave  bus
);
   localparam int AW = $clog2(DEPTH);

   if (DEPTH < CONV_BASE + 3) begin : g_bad_params
      $error("register_file: DEPTH must be >= CONV_BASE+3");
   end

   logic [WIDTH-1:0] regs [DEPTH];
   logic             wr_ok;
   logic             rd_ok;

   // Only reachable when DEPTH is not a power of two.
   assign wr_ok = 32'(bus.sel_in_i) < DEPTH;
   assign rd_ok = 32'(bus.sel_out_i) < DEPTH;

   always_ff @(posedge clock_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < DEPTH; i++) begin
            regs[i] <= '0;
         end
      end else if (bus.clear_i) begin
         for (int i = 0; i < DEPTH; i++) begin
            regs[i] <= '0;
         end
      end else if (bus.load_i && wr_ok) begin
         regs[bus.sel_in_i] <= bus.in_i;
      end
   end

   assign bus.out_o = rd_ok ? regs[bus.sel_out_i] : '0;

   assign bus.out_conversion_o = {
      regs[CONV_BASE+2],
      regs[CONV_BASE+1],
      regs[CONV_BASE]
   };
endmodule

// File: tb/tb_register_file.sv
// Randomised bench for register_file against an array-based model
// of the register contents.
module tb_register_file;
   localparam int DEPTH     = 16;
   localparam int WIDTH     = 8;
   localparam int CONV_BASE = 0;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;

   int n_cmp = 0;
   int n_err = 0;
   int model [DEPTH];

   register_file_if #(.DEPTH(DEPTH), .WIDTH(WIDTH)) bus ();

   register_file #(
      .DEPTH(DEPTH),
      .WIDTH(WIDTH),
      .CONV_BASE(CONV_BASE)
   ) dut (
      .clock_i(clk),
      .rst_ni(rst_n),
      .bus(bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag,
                        input logic [31:0] got,
                        input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] conv_exp();
      int v;
      v = model[CONV_BASE+2] * 65536
        + model[CONV_BASE+1] * 256
        + model[CONV_BASE];
      return 32'(v);
   endfunction

   task automatic model_zero();
      for (int i = 0; i < DEPTH; i++) model[i] = 0;
   endtask

   task automatic sweep(input string tag);
      for (int i = 0; i < DEPTH; i++) begin
         bus.sel_out_i = 4'(i);
         #1;
         check($sformatf("%s[%0d]", tag, i),
               32'(bus.out_o), 32'(model[i]));
      end
      check({tag, "_conv"}, 32'(bus.out_conversion_o), conv_exp());
   endtask

   task automatic op(input int sel, input int din,
                     input bit ld, input bit clr);
      @(negedge clk);
      bus.sel_in_i = 4'(sel);
      bus.in_i     = 8'(din);
      bus.load_i   = ld;
      bus.clear_i  = clr;
      @(posedge clk);
      if (clr) model_zero();
      else if (ld) model[sel] = din & 8'hFF;
      #1;
      bus.load_i  = 1'b0;
      bus.clear_i = 1'b0;
   endtask

   initial begin
      int rd, sel, din;
      bit ld, clr;

      bus.sel_in_i  = '0;
      bus.sel_out_i = '0;
      bus.load_i    = 1'b0;
      bus.clear_i   = 1'b0;
      bus.in_i      = '0;
      model_zero();

      #2 rst_n = 1'b0;
      sweep("reset");
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < DEPTH; i++) op(i, 8'hA0 + i, 1'b1, 1'b0);
      sweep("fill");
      check("fill_conv_const", 32'(bus.out_conversion_o), 32'h00A2A1A0);

      // Same-address read/write: old value before the edge, new after.
      @(negedge clk);
      bus.sel_out_i = 4'd2;
      bus.sel_in_i  = 4'd2;
      bus.in_i      = 8'h11;
      bus.load_i    = 1'b1;
      #1;
      check("raw_pre", 32'(bus.out_o), 32'(model[2]));
      @(posedge clk);
      model[2] = 8'h11;
      #1;
      bus.load_i = 1'b0;
      check("raw_post", 32'(bus.out_o), 32'(model[2]));
      check("raw_conv", 32'(bus.out_conversion_o), 32'h0011A1A0);

      op(7, 8'h5A, 1'b1, 1'b0);
      sweep("isolate");

      op(0, 0, 1'b0, 1'b1);
      sweep("clear");

      for (int i = 0; i < DEPTH; i++) op(i, 8'hA0 + i, 1'b1, 1'b0);
      op(3, 8'h55, 1'b1, 1'b1);
      sweep("clr_vs_ld");

      for (int n = 0; n < 300; n++) begin
         @(negedge clk);
         rd  = int'($urandom_range(0, DEPTH - 1));
         sel = int'($urandom_range(0, DEPTH - 1));
         din = int'($urandom_range(0, 255));
         ld  = ($urandom_range(0, 1) == 1);
         clr = ($urandom_range(0, 31) == 0);
         bus.sel_out_i = 4'(rd);
         bus.sel_in_i  = 4'(sel);
         bus.in_i      = 8'(din);
         bus.load_i    = ld;
         bus.clear_i   = clr;
         #1;
         check("rnd_pre", 32'(bus.out_o), 32'(model[rd]));
         @(posedge clk);
         if (clr) model_zero();
         else if (ld) model[sel] = din;
         #1;
         check("rnd_post", 32'(bus.out_o), 32'(model[rd]));
         check("rnd_conv", 32'(bus.out_conversion_o), conv_exp());
      end
      bus.load_i  = 1'b0;
      bus.clear_i = 1'b0;

      op(0, 8'h3C, 1'b1, 1'b0);
      op(1, 8'hC3, 1'b1, 1'b0);
      op(2, 8'h96, 1'b1, 1'b0);
      op(9, 8'h77, 1'b1, 1'b0);

      // Asynchronous reset: outputs clear before any clock edge.
      @(negedge clk);
      bus.sel_out_i = 4'd9;
      #1;
      check("pre_rst", 32'(bus.out_o), 32'(model[9]));
      rst_n = 1'b0;
      #1;
      check("async_rst_out", 32'(bus.out_o), 32'h0);
      check("async_rst_conv", 32'(bus.out_conversion_o), 32'h0);
      model_zero();
      sweep("rst_mid");
      @(negedge clk);
      rst_n = 1'b1;

      op(5, 8'hE1, 1'b1, 1'b0);
      sweep("post_rst");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
